// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: time-multiplexed driver for a 4-digit common-anode 7-seg
// display. It scans digit 0..3 with an all-dark guard gap between slots,
// snapshots the digit/mask inputs once per frame, and applies blink, blanking,
// decimal points and the colon. Every pin is driven from a register.
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN (blank digit 0 when it is 0).
module sseg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 49999,
    parameter int unsigned GUARD_CYC = 63,
    parameter int unsigned BLINK_DIV = 24999999
) (
    input  logic        M_CLOCK,
    input  logic        M_RESET,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  BLINK_MASK,
    input  logic [3:0]  DP_MASK,
    input  logic        COLON_ON,
    input  logic        BLANK,
    output logic [7:0]  IO_SSEG,
    output logic [3:0]  IO_SSEGD,
    output logic        IO_SSEG_COL,
    output logic        FRAME_TICK
);

    localparam int unsigned SLOT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int unsigned SLOT_W   = (SLOT_MAX > 0) ? $clog2(SLOT_MAX + 1) : 1;
    localparam int unsigned BLINK_W  = (BLINK_DIV > 0) ? $clog2(BLINK_DIV + 1) : 1;

    localparam logic [SLOT_W-1:0]  SCAN_END  = SLOT_W'(SCAN_DIV);
    localparam logic [SLOT_W-1:0]  GUARD_END = SLOT_W'(GUARD_CYC - 1);
    localparam logic [BLINK_W-1:0] BLINK_END = BLINK_W'(BLINK_DIV);

    typedef enum logic {
        GUARD,
        DRIVE
    } state_t;

    state_t             state, stateNext;
    logic [SLOT_W-1:0]  slotCnt, slotCntNext;
    logic [1:0]         idx, idxNext;
    logic               snapLoad;

    logic [BLINK_W-1:0] blinkCnt, blinkCntNext;
    logic               blinkPhase, blinkPhaseNext;

    logic [15:0]        digLatch, digNext;
    logic [3:0]         dpLatch, dpNext;
    logic [3:0]         blinkMaskLatch, blinkMaskNext;

    logic [3:0]         nibble;
    logic [6:0]         seg7;
    logic               lzBlank;
    logic               litNext;
    logic [7:0]         segNext;
    logic [3:0]         segdNext;
    logic               colNext;
    logic               tickNext;

    // Scan sequencer: GUARD for GUARD_CYC cycles, then advance the digit and DRIVE it.
    always_comb begin
        stateNext   = state;
        idxNext     = idx;
        slotCntNext = slotCnt + SLOT_W'(1);
        snapLoad    = 1'b0;
        case (state)
            GUARD: begin
                if (slotCnt == GUARD_END) begin
                    stateNext   = DRIVE;
                    idxNext     = idx + 2'd1;
                    slotCntNext = '0;
                    snapLoad    = (idx == 2'd3);
                end
            end
            DRIVE: begin
                if (slotCnt == SCAN_END) begin
                    stateNext   = GUARD;
                    slotCntNext = '0;
                end
            end
            default: begin
                stateNext = GUARD;
            end
        endcase
    end

    // Blink phase generator and per-frame input snapshot (taken as digit 0 starts).
    always_comb begin
        if (blinkCnt == BLINK_END) begin
            blinkCntNext   = '0;
            blinkPhaseNext = ~blinkPhase;
        end else begin
            blinkCntNext   = blinkCnt + BLINK_W'(1);
            blinkPhaseNext = blinkPhase;
        end
        digNext       = snapLoad ? DIGITS : digLatch;
        dpNext        = snapLoad ? DP_MASK : dpLatch;
        blinkMaskNext = snapLoad ? BLINK_MASK : blinkMaskLatch;
    end

    // Output decode from next-cycle state so the registered pins line up with the scan state.
    always_comb begin
        case (idxNext)
            2'd0:    nibble = digNext[15:12];
            2'd1:    nibble = digNext[11:8];
            2'd2:    nibble = digNext[7:4];
            default: nibble = digNext[3:0];
        endcase
        case (nibble)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h18;
            default: seg7 = 7'h3F;
        endcase
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        lzBlank = (idxNext == 2'd0) && (nibble == 4'd0);
`else
        lzBlank = 1'b0;
`endif
        litNext  = (stateNext == DRIVE) && !BLANK && !lzBlank
                   && !(blinkPhaseNext && blinkMaskNext[idxNext]);
        segNext  = litNext ? {~dpNext[idxNext], seg7} : 8'hFF;
        segdNext = litNext ? ~(4'b0001 << idxNext) : 4'hF;
        colNext  = ~(COLON_ON & ~BLANK);
        tickNext = (stateNext == DRIVE) && (idxNext == 2'd3) && (slotCntNext == SCAN_END);
    end

    // State, counters, snapshot latch and registered pins.
    always_ff @(posedge M_CLOCK) begin
        if (M_RESET) begin
            state          <= GUARD;
            idx            <= 2'd3;
            slotCnt        <= '0;
            blinkCnt       <= '0;
            blinkPhase     <= 1'b0;
            digLatch       <= '0;
            dpLatch        <= '0;
            blinkMaskLatch <= '0;
            IO_SSEG        <= 8'hFF;
            IO_SSEGD       <= 4'hF;
            IO_SSEG_COL    <= 1'b1;
            FRAME_TICK     <= 1'b0;
        end else begin
            state          <= stateNext;
            idx            <= idxNext;
            slotCnt        <= slotCntNext;
            blinkCnt       <= blinkCntNext;
            blinkPhase     <= blinkPhaseNext;
            digLatch       <= digNext;
            dpLatch        <= dpNext;
            blinkMaskLatch <= blinkMaskNext;
            IO_SSEG        <= segNext;
            IO_SSEGD       <= segdNext;
            IO_SSEG_COL    <= colNext;
            FRAME_TICK     <= tickNext;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Testbench for sseg_scan_driver with SCAN_DIV=3, GUARD_CYC=1, BLINK_DIV=15.
// Stimulus pushes hand-computed lit slots {enable, segments, length} into a
// queue; a negedge monitor collects each lit run and compares it to the queue.
module tb_sseg_scan_driver;

    logic        M_CLOCK;
    logic        M_RESET;
    logic [15:0] DIGITS;
    logic [3:0]  BLINK_MASK;
    logic [3:0]  DP_MASK;
    logic        COLON_ON;
    logic        BLANK;
    logic [7:0]  IO_SSEG;
    logic [3:0]  IO_SSEGD;
    logic        IO_SSEG_COL;
    logic        FRAME_TICK;

    sseg_scan_driver #(
        .SCAN_DIV (3),
        .GUARD_CYC(1),
        .BLINK_DIV(15)
    ) dut (
        .M_CLOCK    (M_CLOCK),
        .M_RESET    (M_RESET),
        .DIGITS     (DIGITS),
        .BLINK_MASK (BLINK_MASK),
        .DP_MASK    (DP_MASK),
        .COLON_ON   (COLON_ON),
        .BLANK      (BLANK),
        .IO_SSEG    (IO_SSEG),
        .IO_SSEGD   (IO_SSEGD),
        .IO_SSEG_COL(IO_SSEG_COL),
        .FRAME_TICK (FRAME_TICK)
    );

    initial M_CLOCK = 1'b0;
    always #5 M_CLOCK = ~M_CLOCK;

    typedef struct {
        logic [3:0]  en;
        logic [7:0]  seg;
        int unsigned len;
    } slot_t;

    slot_t       expQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;
    bit          monEn = 1'b0;
    int          k = 0;

    logic [3:0]  runEn;
    logic [7:0]  runSeg;
    int unsigned runLen;
    bit          runActive = 1'b0;
    bit          runTracked = 1'b0;
    logic [3:0]  prevD = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic pushSlot(input logic [3:0] en, input logic [7:0] seg, input int unsigned len);
        slot_t s;
        s.en  = en;
        s.seg = seg;
        s.len = len;
        expQ.push_back(s);
    endtask

    task automatic pushFrame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        pushSlot(4'hE, s0, 4);
        pushSlot(4'hD, s1, 4);
        pushSlot(4'hB, s2, 4);
        pushSlot(4'h7, s3, 4);
    endtask

    task automatic closeRun();
        slot_t s;
        if (runTracked) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL slot_unexpected actual=en %h seg %h len %0d required=no slot",
                         runEn, runSeg, runLen);
            end else begin
                s = expQ.pop_front();
                if (s.en !== runEn || s.seg !== runSeg || s.len != runLen) begin
                    errors++;
                    $display("FAIL slot actual=en %h seg %h len %0d required=en %h seg %h len %0d",
                             runEn, runSeg, runLen, s.en, s.seg, s.len);
                end
            end
        end
        runActive = 1'b0;
    endtask

    // Monitor: enable legality, dark gap before every slot, and lit-run scoreboard.
    always @(negedge M_CLOCK) begin
        if (started) begin
            check("enable_onehot",
                  32'(IO_SSEGD inside {4'hF, 4'hE, 4'hD, 4'hB, 4'h7}), 32'd1);
            if (runActive && (IO_SSEGD != runEn || IO_SSEG != runSeg))
                closeRun();
            if (runActive) begin
                runLen++;
            end else if (IO_SSEGD != 4'hF) begin
                check("dark_before_slot", 32'(prevD), 32'hF);
                runActive  = 1'b1;
                runTracked = monEn;
                runEn      = IO_SSEGD;
                runSeg     = IO_SSEG;
                runLen     = 1;
            end
            prevD = IO_SSEGD;
        end
    end

    task automatic step();
        @(posedge M_CLOCK);
        #1;
        k++;
    endtask

    task automatic doReset();
        @(posedge M_CLOCK);
        #1;
        M_RESET = 1'b1;
        @(posedge M_CLOCK);
        #1;
        M_RESET = 1'b0;
        k       = 0;
        started = 1'b1;
        check("reset_sseg", 32'(IO_SSEG), 32'hFF);
        check("reset_ssegd", 32'(IO_SSEGD), 32'hF);
        check("reset_col", 32'(IO_SSEG_COL), 32'd1);
        check("reset_tick", 32'(FRAME_TICK), 32'd0);
    endtask

    task automatic waitEnable(input logic [3:0] en);
        int n = 0;
        do begin
            step();
            n++;
        end while (IO_SSEGD !== en && n < 100);
        check("wait_enable", 32'(IO_SSEGD), 32'(en));
    endtask

    task automatic waitTick(output int at);
        int n = 0;
        do begin
            step();
            n++;
        end while (FRAME_TICK !== 1'b1 && n < 100);
        at = k;
    endtask

    task automatic drainQueue();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("queue_drained", 32'(expQ.size()), 32'd0);
        monEn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1;
        int t2;
        M_RESET    = 1'b1;
        DIGITS     = 16'h1234;
        BLINK_MASK = 4'b0000;
        DP_MASK    = 4'b0000;
        COLON_ON   = 1'b0;
        BLANK      = 1'b0;

        // Reset, plain scan order, frame tick latency and period.
        doReset();
        monEn = 1'b1;
        pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        waitTick(t1);
        check("first_tick_cycle", 32'(t1), 32'd19);
        waitTick(t2);
        check("tick_period", 32'(t2 - t1), 32'd20);
        step();
        check("tick_one_cycle", 32'(FRAME_TICK), 32'd0);
        drainQueue();

        // Mid-frame digit change shows only from the next frame; 10..15 give a dash.
        DIGITS = 16'h1234;
        doReset();
        monEn = 1'b1;
        pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        waitEnable(4'hD);
        DIGITS = 16'h0959;
        pushFrame(8'hC0, 8'h98, 8'h92, 8'h98);
        waitEnable(4'hE);
        DIGITS = 16'hA5FC;
        pushFrame(8'hBF, 8'h92, 8'hBF, 8'hBF);
        drainQueue();

        // Blink on digit 0 with 16-cycle phases; dp on digit 1.
        DIGITS     = 16'h1234;
        BLINK_MASK = 4'b0001;
        DP_MASK    = 4'b0010;
        doReset();
        monEn = 1'b1;
        pushFrame(8'hF9, 8'h24, 8'hB0, 8'h99);
        pushSlot(4'hD, 8'h24, 4);
        pushSlot(4'hB, 8'hB0, 4);
        pushSlot(4'h7, 8'h99, 4);
        pushFrame(8'hF9, 8'h24, 8'hB0, 8'h99);
        pushSlot(4'hE, 8'hF9, 1);
        pushSlot(4'hD, 8'h24, 4);
        pushSlot(4'hB, 8'hB0, 4);
        pushSlot(4'h7, 8'h99, 4);
        drainQueue();

        // BLANK mid-slot, release keeps slot position; colon follows in one cycle.
        BLINK_MASK = 4'b0000;
        DP_MASK    = 4'b0000;
        COLON_ON   = 1'b1;
        doReset();
        monEn = 1'b1;
        pushSlot(4'hE, 8'hF9, 4);
        pushSlot(4'hD, 8'hA4, 2);
        pushSlot(4'hB, 8'hB0, 2);
        pushSlot(4'h7, 8'h99, 4);
        pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99);
        while (k < 20) begin
            step();
            if (k == 1) check("colon_on_latency", 32'(IO_SSEG_COL), 32'd0);
            if (k == 7) BLANK = 1'b1;
            if (k == 8) begin
                check("blank_ssegd", 32'(IO_SSEGD), 32'hF);
                check("blank_sseg", 32'(IO_SSEG), 32'hFF);
                check("blank_col", 32'(IO_SSEG_COL), 32'd1);
            end
            if (k == 12) BLANK = 1'b0;
            if (k == 13) begin
                check("release_col", 32'(IO_SSEG_COL), 32'd0);
                check("release_slot", 32'(IO_SSEGD), 32'hB);
            end
            if (k == 15) COLON_ON = 1'b0;
            if (k == 16) begin
                check("colon_off", 32'(IO_SSEG_COL), 32'd1);
                COLON_ON = 1'b1;
            end
            if (k == 17) check("colon_on_again", 32'(IO_SSEG_COL), 32'd0);
            if (k == 19) check("tick_through_blank", 32'(FRAME_TICK), 32'd1);
        end
        drainQueue();

        // Leading-zero handling of digit 0 (dp requested on digit 0).
        DIGITS  = 16'h0905;
        DP_MASK = 4'b0001;
        doReset();
        monEn = 1'b1;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        pushSlot(4'hD, 8'h98, 4);
`else
        pushSlot(4'hE, 8'h40, 4);
        pushSlot(4'hD, 8'h98, 4);
`endif
        pushSlot(4'hB, 8'hC0, 4);
        pushSlot(4'h7, 8'h92, 4);
        drainQueue();

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
